// File: rtl/gel_compare_ctrl_pkg.sv
// Shared GEL result codes and controller state encoding; also used by the
// GEL-to-segment decoder.
package gel_compare_ctrl_pkg;

    localparam logic [2:0] GEL_GT   = 3'b100;
    localparam logic [2:0] GEL_EQ   = 3'b010;
    localparam logic [2:0] GEL_LT   = 3'b001;
    localparam logic [2:0] GEL_NONE = 3'b000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/gel_compare_ctrl.sv
// Serial MSB-first magnitude comparator controller with start/busy/done handshake.
// Define COMPARE_SIGNED_EN to treat the operands as two's-complement.
module gel_compare_ctrl
    import gel_compare_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    output logic                     busy,
    output logic                     done,
    output logic [2:0]               gel,
    output logic [$clog2(WIDTH)-1:0] bit_idx
);

    localparam int unsigned IW = $clog2(WIDTH);
    localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);

    state_t            state, state_nx;
    logic [WIDTH-1:0]  ra, rb;
    logic              bit_a, bit_b;
    logic              gt, lt, last;
    logic              accept;

    assign bit_a = ra[bit_idx];
    assign bit_b = rb[bit_idx];
    assign last  = (bit_idx == '0);

`ifdef COMPARE_SIGNED_EN
    // Sign bit carries inverted weight; lower bits compare as unsigned.
    always_comb begin
        gt = bit_a & ~bit_b;
        lt = ~bit_a & bit_b;
        if (bit_idx == IDX_TOP) begin
            gt = ~bit_a & bit_b;
            lt = bit_a & ~bit_b;
        end
    end
`else
    always_comb begin
        gt = bit_a & ~bit_b;
        lt = ~bit_a & bit_b;
    end
`endif

    assign accept = (state != S_SHIFT) && start && !abort;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = S_IDLE;
        case (state)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_nx = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    state_nx = S_IDLE;
                end else if (gt || lt || last) begin
                    state_nx = S_DONE;
                end else begin
                    state_nx = S_SHIFT;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_SHIFT);
        done = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ra      <= '0;
            rb      <= '0;
            gel     <= GEL_NONE;
            bit_idx <= IDX_TOP;
        end else if (accept) begin
            ra      <= a;
            rb      <= b;
            bit_idx <= IDX_TOP;
        end else if (state == S_SHIFT && !abort) begin
            if (gt) begin
                gel <= GEL_GT;
            end else if (lt) begin
                gel <= GEL_LT;
            end else if (last) begin
                gel <= GEL_EQ;
            end else begin
                bit_idx <= bit_idx - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gel_compare_ctrl.sv
// Directed self-checking bench for gel_compare_ctrl at WIDTH=8.
module tb_gel_compare_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [2:0] gel;
    logic [2:0] bit_idx;

    int checks = 0;
    int errors = 0;

    gel_compare_ctrl #(.WIDTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .abort   (abort),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .gel     (gel),
        .bit_idx (bit_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch an op; count edges after the accepting edge until done is seen.
    task automatic run_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                          input bit scramble, input int exp_edges, input logic [2:0] exp_gel);
        int  edges;
        bit  busy_ok;
        a = va;
        b = vb;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy_start"}, busy, 1'b1);
        if (scramble) begin
            a = ~va;
            b = ~vb;
        end
        edges = 0;
        busy_ok = 1'b1;
        while (!done && edges <= 20) begin
            if (!busy) busy_ok = 1'b0;
            tick();
            edges++;
        end
        check({tag, "_latency"}, edges, exp_edges);
        check({tag, "_busy_held"}, busy_ok, 1'b1);
        check({tag, "_gel"}, gel, exp_gel);
        check({tag, "_busy_at_done"}, busy, 1'b0);
    endtask

    initial begin
        logic [2:0] exp_signed;
`ifdef COMPARE_SIGNED_EN
        exp_signed = 3'b001;
`else
        exp_signed = 3'b100;
`endif
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        a = '0;
        b = '0;
        tick();
        tick();
        reset = 1'b0;
        repeat (5) tick();
        check("rst_gel", gel, 3'b000);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_idx", bit_idx, 3'd7);

        run_op("msb", 8'h80, 8'h7F, 1'b0, 1, exp_signed);
        tick();
        check("done_pulse", done, 1'b0);

        run_op("eq", 8'h5A, 8'h5A, 1'b0, 8, 3'b010);
        tick();
        run_op("lsb", 8'h12, 8'h13, 1'b1, 8, 3'b001);
        // start during the DONE cycle re-enters SHIFT immediately
        run_op("b2b", 8'hFF, 8'h00, 1'b0, 1, 3'b100);
        tick();

        // abort mid-SHIFT with start held throughout
        a = 8'h01;
        b = 8'h01;
        start = 1'b1;
        tick();
        tick();
        tick();
        check("start_ignored_idx", bit_idx, 3'd5);
        check("start_ignored_busy", busy, 1'b1);
        abort = 1'b1;
        tick();
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_gel", gel, 3'b100);
        tick();
        check("abort_wins_busy", busy, 1'b0);
        start = 1'b0;
        abort = 1'b0;
        tick();
        check("abort_idle_done", done, 1'b0);

        // reset mid-SHIFT
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_gel", gel, 3'b000);
        check("midrst_idx", bit_idx, 3'd7);
        tick();
        check("midrst_stay_idle", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gel_compare_ctrl.md
# gel_compare_ctrl

Sequencing controller for the comparator datapath in the midterm design. It captures two unsigned operands on a start request, compares them serially MSB-first with early termination, and produces a registered one-hot greater/equal/less code (GEL) for the downstream GEL-to-segment decoder. It also provides a start/busy/done handshake so the board-level top can drive it from debounced push-buttons.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..16.
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high; sampled on the clk rising edge.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- abort  input  1  cancels an in-progress compare.
- a  input  WIDTH  operand A; sampled in the cycle start is accepted.
- b  input  WIDTH  operand B; sampled in the cycle start is accepted.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse when a result is written.
- gel  output  3  result code: 3'b100 means A>B, 3'b010 means A==B, 3'b001 means A<B, 3'b000 means no result yet.
- bit_idx  output  log2(WIDTH)  index of the bit being compared; used for debug LEDs.

## Operation
- States:
  - IDLE: waits for start.
  - SHIFT: compares one bit per cycle.
  - DONE: lasts one cycle; done=1.
- IDLE → SHIFT on start=1 and abort=0.
  - Latch a and b into internal registers.
  - Set bit_idx to WIDTH-1.
- SHIFT, each cycle, compare ra[bit_idx] with rb[bit_idx]:
  - ra bit=1, rb bit=0: gel←100, go to DONE.
  - ra bit=0, rb bit=1: gel←001, go to DONE.
  - Bits equal and bit_idx==0: gel←010, go to DONE.
  - Bits equal and bit_idx>0: decrement bit_idx, stay in SHIFT.
- SHIFT with abort=1 (abort has priority over the compare):
  - Go to IDLE.
  - gel keeps its previous value; no done pulse.
- DONE:
  - start=1 is accepted exactly as in IDLE, so back-to-back operations are possible.
  - Otherwise go to IDLE.
- start in SHIFT is ignored; no queueing.
- start and abort both high in IDLE or DONE: abort wins, next state is IDLE.
- gel changes only on the edge that enters DONE. It holds until the next DONE or reset, and is not cleared by a new start.
- Operands are captured, so changes to a or b after acceptance have no effect.
- Outputs after reset:
  - State is IDLE.
  - gel=000, busy=0, done=0, bit_idx=WIDTH-1.
  - Internal operand registers are 0.
  - Reset asserted mid-SHIFT discards the operation.

## Timing
- start accepted at edge t: busy=1 from t+1.
- First difference at bit k: gel is valid and done=1 at cycle t+1+(WIDTH-k).
  - WIDTH=8, MSB difference: done at t+2.
- Equal operands: done at t+WIDTH+1.
- Worst-case latency is WIDTH+1 cycles. Throughput is 1 result per WIDTH+1 cycles, because start in DONE re-enters SHIFT.
- busy falls in the same cycle done rises.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- COMPARE_SIGNED_EN defined: operands are two's-complement.
  - Only the bit_idx==WIDTH-1 comparison is inverted: ra MSB=1 with rb MSB=0 gives 001, and the reverse gives 100.
  - Lower bits are compared as in unsigned mode.
- COMPARE_SIGNED_EN undefined: pure unsigned compare; no signed logic is synthesized.
- Latency is identical in both modes.

## Structure
- Shared package/header constants:
  - GEL_GT=3'b100, GEL_EQ=3'b010, GEL_LT=3'b001, GEL_NONE=3'b000.
  - State encodings S_IDLE, S_SHIFT, S_DONE.
  - The segment decoder uses the same GEL constants.
- Single module; no sub-module. The FSM, operand registers and index counter are too small to split.
- The top level instantiates this block feeding the existing GEL-to-segment decoder.

## Test plan
All scenarios use WIDTH=8.
- Reset, then idle 5 cycles → gel=000, busy=0, done=0, bit_idx=7.
- a=8'h80, b=8'h7F, start at t (unsigned build) → done at t+2, gel=100.
  - Same stimulus in the COMPARE_SIGNED_EN build → gel=001.
- a=8'h5A, b=8'h5A → busy for 8 cycles, done at t+9, gel=010.
- a=8'h12, b=8'h13 → difference at bit 0, done at t+9, gel=001.
  - Change a and b mid-compare → result unchanged.
- a=8'h01, b=8'h01 with abort asserted at t+3 → IDLE at t+4, no done, gel retains its prior value.
  - start held during SHIFT → ignored.
- start in the DONE cycle with a=8'hFF, b=8'h00 → new op, done 2 cycles later, gel=100.
  - Reset asserted mid-SHIFT → IDLE next cycle, gel=000.
